comp_pipe: RTL and testbench



---
 rtl/comp_pipe.sv | 132 +++++++++++++
 tb/tb_comp_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/comp_pipe.sv
// comp_pipe: parametrised, pipelined magnitude comparator with valid tagging
// and a saturating hit counter.
// Optional feature macro: COMP_PIPE_STICKY_EN (sticky hit flag; tied to 0 when
// the macro is undefined).
module comp_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             signed_en,
  input  logic             clear,
  output logic             out_valid,
  output logic             z,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_sticky
);

  // Packed pipeline word: {valid, mode, operand A, operand B}
  localparam int unsigned PW = 1 + 3 + 2 * WIDTH;

  logic [WIDTH-1:0] msb_flip;
  logic [PW-1:0]    s_in;
  logic [PW-1:0]    s_cmp;

  // Signed compare is done as unsigned after inverting both MSBs, so the
  // operands are biased once at capture and travel down the pipe as unsigned.
  assign msb_flip = signed_en ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  assign s_in     = {in_valid, mode, a ^ msb_flip, b ^ msb_flip};

  generate
    if (STAGES == 1) begin : g_direct
      assign s_cmp = s_in;
    end else begin : g_pipe
      logic [PW-1:0] pipe [STAGES-1];

      // Operand/control stages ahead of the final flag register
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < STAGES - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= s_in;
          for (int unsigned i = 1; i < STAGES - 1; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign s_cmp = pipe[STAGES-2];
    end
  endgenerate

  logic             c_valid;
  logic [2:0]       c_mode;
  logic [WIDTH-1:0] c_a;
  logic [WIDTH-1:0] c_b;
  logic             gt_c;
  logic             eq_c;
  logic             lt_c;
  logic             z_c;

  assign {c_valid, c_mode, c_a, c_b} = s_cmp;

  // Magnitude compare and mode select
  always_comb begin
    gt_c = 1'b0;
    eq_c = 1'b0;
    lt_c = 1'b0;
    z_c  = 1'b0;
    gt_c = c_a > c_b;
    eq_c = c_a == c_b;
    lt_c = c_a < c_b;
    case (c_mode)
      3'b000:  z_c = gt_c;
      3'b001:  z_c = gt_c | eq_c;
      3'b010:  z_c = lt_c;
      3'b011:  z_c = lt_c | eq_c;
      3'b100:  z_c = eq_c;
      3'b101:  z_c = ~eq_c;
      default: z_c = 1'b0;
    endcase
  end

  // Final stage: registered flags, forced to 0 for bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      out_valid <= c_valid;
      z         <= c_valid & z_c;
      gt        <= c_valid & gt_c;
      eq        <= c_valid & eq_c;
      lt        <= c_valid & lt_c;
    end
  end

  logic hit;
  assign hit = out_valid & z;

  // Saturating hit counter; clear beats a coincident increment
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hit_count <= '0;
    end else if (hit && (hit_count != '1)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

`ifdef COMP_PIPE_STICKY_EN
  // Sticky hit flag, held until rst or clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hit_sticky <= 1'b0;
    end else if (hit) begin
      hit_sticky <= 1'b1;
    end
  end
`else
  assign hit_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_comp_pipe.sv
// tb_comp_pipe: directed self-checking bench for comp_pipe. Two instances share
// the stimulus: u_dut (defaults, STAGES=2) and u_sat (STAGES=4, CNT_W=4).
`timescale 1ns/1ps
module tb_comp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  mode;
  logic        signed_en;
  logic        clear;

  logic        d_ov, d_z, d_gt, d_eq, d_lt, d_st;
  logic [15:0] d_cnt;
  logic        s_ov, s_z, s_gt, s_eq, s_lt, s_st;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;
  logic exp_st;

  always #5 clk = ~clk;

  comp_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .signed_en(signed_en), .clear(clear), .out_valid(d_ov), .z(d_z),
    .gt(d_gt), .eq(d_eq), .lt(d_lt), .hit_count(d_cnt), .hit_sticky(d_st)
  );

  comp_pipe #(.WIDTH(32), .STAGES(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .signed_en(signed_en), .clear(clear), .out_valid(s_ov), .z(s_z),
    .gt(s_gt), .eq(s_eq), .lt(s_lt), .hit_count(s_cnt), .hit_sticky(s_st)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic [2:0] vm, input logic vs);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    mode      = vm;
    signed_en = vs;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    mode     = 3'b111;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Send one result and check u_dut flags two cycles after it was presented
  task automatic one_shot(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [2:0] vm, input logic vs,
                          input logic ez, input logic egt, input logic eeq, input logic elt);
    drive(va, vb, vm, vs);
    tick();
    idle();
    a = ~va;
    b = ~vb;
    chk({tag, ".ov_early"}, d_ov, 1'b0);
    tick();
    chk({tag, ".ov"}, d_ov, 1'b1);
    chk({tag, ".z"}, d_z, ez);
    chk({tag, ".flags"}, {d_gt, d_eq, d_lt}, {egt, eeq, elt});
    tick();
    chk({tag, ".ov_after"}, d_ov, 1'b0);
    chk({tag, ".z_after"}, {d_z, d_gt, d_eq, d_lt}, 4'b0000);
  endtask

  initial begin
    logic [5:0] zseq;
    zseq  = 6'b101100;  // bit i = expected z for mode i with a=14, b=15
`ifdef COMP_PIPE_STICKY_EN
    exp_st = 1'b1;
`else
    exp_st = 1'b0;
`endif
    rst       = 1'b1;
    clear     = 1'b0;
    signed_en = 1'b0;
    idle();
    tick();
    tick();
    chk("rst.outs", {d_ov, d_z, d_gt, d_eq, d_lt, d_st}, 6'b0);
    chk("rst.cnt", d_cnt, 16'd0);
    chk("rst.sat", {s_ov, s_z, s_cnt, s_st}, 7'b0);
    rst = 1'b0;

    one_shot("gt32", 32'd3, 32'd2, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    one_shot("lt01", 32'd0, 32'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    one_shot("sgn1", 32'hFFFFFFFF, 32'h1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    one_shot("sgn0", 32'hFFFFFFFF, 32'h1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    one_shot("mode6", 32'd5, 32'd5, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    one_shot("sgnmin", 32'h80000000, 32'h7FFFFFFF, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back mode sweep
    for (int i = 0; i < 6; i++) begin
      drive(32'd14, 32'd15, 3'(i), 1'b0);
      tick();
      if (i >= 1) begin
        chk($sformatf("sweep.ov%0d", i - 1), d_ov, 1'b1);
        chk($sformatf("sweep.z%0d", i - 1), d_z, zseq[i-1]);
      end
    end
    idle();
    tick();
    chk("sweep.ov5", d_ov, 1'b1);
    chk("sweep.z5", d_z, zseq[5]);
    tick();
    one_shot("eq14", 32'd14, 32'd14, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Saturation: 17 hits, u_sat (CNT_W=4) must stop at 15
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(32'd3, 32'd2, 3'b000, 1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("sat.cnt15", s_cnt, 4'd15);
    chk("sat.cnt17", d_cnt, 16'd17);

    // Clear coinciding with a u_sat hit
    drive(32'd3, 32'd2, 3'b000, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("clr.hit_pending", {s_ov, s_z}, 2'b11);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr.sat", s_cnt, 4'd0);
    chk("clr.dut", d_cnt, 16'd0);

    // Reset while three hits are in flight in u_sat
    drive(32'd3, 32'd2, 3'b000, 1'b0);
    tick();
    tick();
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rstmid.ov%0d", i), {s_ov, d_ov}, 2'b00);
      chk($sformatf("rstmid.cnt%0d", i), {s_cnt, d_cnt}, 20'd0);
      tick();
    end

    // Sticky flag: one hit then ten non-hit results
    chk("st.init", d_st, 1'b0);
    drive(32'd3, 32'd2, 3'b000, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(32'd0, 32'd1, 3'b000, 1'b0);
      tick();
      if (i >= 2) chk($sformatf("st.hold%0d", i), d_st, exp_st);
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("st.end", d_st, exp_st);
    chk("st.cnt", d_cnt, 16'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("st.clr", d_st, 1'b0);
    chk("st.clrsat", s_st, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
